gf180mcu_clkdiv_gate: RTL

GF180MCU_CLKDIV_GATE -- requirements
Module: gf180mcu_clkdiv_gate

---
 rtl/gf180mcu_clkdiv_gate.sv | 102 ++++++++++
 1 files changed

// File: rtl/gf180mcu_clkdiv_gate.sv
// Gated integer clock divider: Z = CLK / (DIV+2), glitch-free start/stop.
// Ports: CLK, RST (sync, active-high), EN, DIV/DIV_REQ/DIV_ACK, Z, TICK, ACTIVE.
module gf180mcu_clkdiv_gate #(
  parameter int DIV_W   = 4,
  parameter int DIV_RST = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  input  logic             DIV_REQ,
  output logic             DIV_ACK,
  output logic             Z,
  output logic             TICK,
  output logic             ACTIVE
);

  localparam int CW = DIV_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_n;
  logic [DIV_W-1:0] pend_d;
  logic             pend_v;
  logic             req_q;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [CW-1:0]    last;
  logic [CW-1:0]    half_n;
  logic             wrap;
  logic             cap;
  logic             load;
  logic             act_n;

  always_comb begin
    last    = CW'(div_r) + CW'(1);
    wrap    = (cnt == last);
    cap     = DIV_REQ && !req_q && !pend_v;
    state_n = state;
    cnt_n   = '0;
    unique case (state)
      IDLE: begin
        if (EN) state_n = RUN;
      end
      RUN: begin
        cnt_n = wrap ? '0 : cnt + CW'(1);
        // EN dropped on the last cycle: no further period to finish
        if (!EN) state_n = wrap ? IDLE : STOP;
      end
      STOP: begin
        cnt_n = wrap ? '0 : cnt + CW'(1);
        if (EN)        state_n = RUN;
        else if (wrap) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // new divisor only at a period boundary so no phase is cut short
    load   = pend_v && ((state == IDLE) || wrap);
    div_n  = load ? pend_d : div_r;
    half_n = (CW'(div_n) + CW'(3)) >> 1;
    act_n  = (state_n != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      div_r   <= DIV_W'(DIV_RST);
      pend_v  <= 1'b0;
      pend_d  <= '0;
      // track DIV_REQ so a level held across reset is not an edge
      req_q   <= DIV_REQ;
      Z       <= 1'b0;
      TICK    <= 1'b0;
      DIV_ACK <= 1'b0;
      ACTIVE  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div_r   <= div_n;
      req_q   <= DIV_REQ;
      if (cap) begin
        pend_v <= 1'b1;
        pend_d <= DIV;
      end else if (load) begin
        pend_v <= 1'b0;
      end
      Z       <= act_n && (cnt_n < half_n);
      TICK    <= act_n && (cnt_n == '0);
      DIV_ACK <= load;
      ACTIVE  <= act_n;
    end
  end

endmodule
